// File: rtl/sha512unit_dispatcher_pkg.sv
// Shared definitions for the sha512unit dispatcher.
//   UNIT_INPUT_WIDTH : default word width of the upstream FIFO and unit input bus
//   PKT_TYPE_*       : header type codes carried in din[2:0] of a header word
//   ST_*             : dispatcher FSM state encodings
package sha512unit_dispatcher_pkg;

    localparam int unsigned UNIT_INPUT_WIDTH = 8;

    localparam logic [2:0] PKT_TYPE_DATA = 3'b000;
    localparam logic [2:0] PKT_TYPE_INIT = 3'b001;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SELECT    = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_INIT_WAIT = 3'd3;
    localparam logic [2:0] ST_INIT_SEND = 3'd4;

    // Any header whose type code is not INIT is treated as a data packet.
    function automatic logic is_init_header(input logic [2:0] code);
        return code == PKT_TYPE_INIT;
    endfunction

endpackage

// File: rtl/sha512unit_dispatcher_rr_select.sv
// Round-robin first-set-bit finder.
//   i_avail  : candidate units (bit per unit)
//   i_rr_ptr : unit to start the search at
//   o_sel    : first set bit at or after i_rr_ptr, wrapping around
//   o_found  : at least one bit of i_avail is set
// Purely combinational.
module sha512unit_dispatcher_rr_select #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [N_UNITS-1:0] i_avail,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [PTR_W-1:0]   o_sel,
    output logic               o_found
);

    always_comb begin
        int idx;
        idx     = 0;
        o_sel   = '0;
        o_found = 1'b0;
        for (int k = 0; k < int'(N_UNITS); k++) begin
            idx = (int'(i_rr_ptr) + k) % int'(N_UNITS);
            if (!o_found && i_avail[idx]) begin
                o_found = 1'b1;
                o_sel   = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sha512unit_dispatcher.sv
// Dispatches packets from the upstream FWFT FIFO onto the shared sha512unit input bus.
// Data packets go to one idle unit chosen round-robin; init packets are broadcast to
// all units once every unit is ready.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_din, i_din_ctrl   : upstream FIFO head word and its control flag
//   i_din_empty         : upstream FIFO empty
//   o_din_rd_en         : pop upstream word (combinational)
//   o_unit_in(_ctrl)    : registered shared bus word / control flag
//   o_unit_in_wr_en     : registered per-unit write enable
//   i_unit_in_afull     : per-unit almost-full (>= 2 words slack)
//   i_unit_in_ready     : per-unit ready for a new packet
//   o_idle              : IDLE state with no holdoff pending
//   o_err_protocol      : sticky, a data word was seen where a header belonged
//   o_pkt_count         : data packets dispatched, wraps at 2^16
module sha512unit_dispatcher #(
    parameter int unsigned N_UNITS          = 4,
    parameter int unsigned UNIT_INPUT_WIDTH = sha512unit_dispatcher_pkg::UNIT_INPUT_WIDTH,
    parameter int unsigned HOLDOFF          = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [UNIT_INPUT_WIDTH-1:0] i_din,
    input  logic                        i_din_ctrl,
    input  logic                        i_din_empty,
    output logic                        o_din_rd_en,
    output logic [UNIT_INPUT_WIDTH-1:0] o_unit_in,
    output logic                        o_unit_in_ctrl,
    output logic [N_UNITS-1:0]          o_unit_in_wr_en,
    input  logic [N_UNITS-1:0]          i_unit_in_afull,
    input  logic [N_UNITS-1:0]          i_unit_in_ready,
    output logic                        o_idle,
    output logic                        o_err_protocol,
    output logic [15:0]                 o_pkt_count
);

    import sha512unit_dispatcher_pkg::*;

    localparam int unsigned PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int unsigned HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [2:0]                  r_state;
    logic [2:0]                  w_state_d;
    logic [PTR_W-1:0]            r_rr_ptr;
    logic [PTR_W-1:0]            r_sel;
    logic [PTR_W-1:0]            w_rr_sel;
    logic [PTR_W-1:0]            w_sel_next;
    logic                        w_rr_found;
    logic                        r_hdr_seen;
    logic [HO_W-1:0]             r_holdoff [N_UNITS];
    logic [N_UNITS-1:0]          w_hold_mask;
    logic [N_UNITS-1:0]          w_avail;
    logic [N_UNITS-1:0]          w_sel_onehot;
    logic [UNIT_INPUT_WIDTH-1:0] r_unit_in;
    logic                        r_unit_in_ctrl;
    logic [N_UNITS-1:0]          r_wr_en;
    logic                        r_err;
    logic [15:0]                 r_pkt_count;
    logic                        w_in_send;
    logic                        w_gate;
    logic                        w_pop_fwd;
    logic                        w_pop_stray;
    logic                        w_end;
    logic                        w_end_data;

    always_comb begin
        for (int i = 0; i < int'(N_UNITS); i++) begin
            w_hold_mask[i] = r_holdoff[i] != '0;
        end
    end

    assign w_avail      = i_unit_in_ready & ~w_hold_mask;
    assign w_sel_onehot = N_UNITS'(1) << r_sel;
    assign w_sel_next   = (r_sel == PTR_W'(N_UNITS - 1)) ? '0 : r_sel + 1'b1;

    sha512unit_dispatcher_rr_select #(
        .N_UNITS (N_UNITS),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .i_avail  (w_avail),
        .i_rr_ptr (r_rr_ptr),
        .o_sel    (w_rr_sel),
        .o_found  (w_rr_found)
    );

    // Only the selected unit's afull matters during a data packet; a broadcast must
    // respect every unit.
    assign w_in_send   = (r_state == ST_SEND) || (r_state == ST_INIT_SEND);
    assign w_gate      = (r_state == ST_SEND) ? i_unit_in_afull[r_sel] : |i_unit_in_afull;
    assign w_pop_fwd   = i_rst_n & ~i_din_empty & w_in_send & ~w_gate;
    assign w_pop_stray = i_rst_n & ~i_din_empty & (r_state == ST_IDLE) & ~i_din_ctrl;
    assign o_din_rd_en = w_pop_fwd | w_pop_stray;

    // The first ctrl word popped is the header; the next one terminates the packet.
    assign w_end      = w_pop_fwd & i_din_ctrl & r_hdr_seen;
    assign w_end_data = w_end & (r_state == ST_SEND);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_din_empty && i_din_ctrl) begin
                    w_state_d = is_init_header(i_din[2:0]) ? ST_INIT_WAIT : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_rr_found) begin
                    w_state_d = ST_SEND;
                end
            end
            ST_SEND, ST_INIT_SEND: begin
                if (w_end) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_INIT_WAIT: begin
                if ((&i_unit_in_ready) && !(|w_hold_mask)) begin
                    w_state_d = ST_INIT_SEND;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_sel       <= '0;
            r_hdr_seen  <= 1'b0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == ST_SELECT && w_rr_found) begin
                r_sel <= w_rr_sel;
            end
            if (w_pop_fwd) begin
                r_hdr_seen <= ~w_end;
            end
            if (w_end_data) begin
                r_rr_ptr    <= w_sel_next;
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_pop_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    // A reload for the unit just finished takes precedence over its decrement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N_UNITS); i++) begin
                r_holdoff[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_UNITS); i++) begin
                if (w_end_data && r_sel == PTR_W'(i)) begin
                    r_holdoff[i] <= HO_W'(HOLDOFF);
                end else if (r_holdoff[i] != '0) begin
                    r_holdoff[i] <= r_holdoff[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_unit_in      <= '0;
            r_unit_in_ctrl <= 1'b0;
            r_wr_en        <= '0;
        end else begin
            if (w_pop_fwd) begin
                r_unit_in      <= i_din;
                r_unit_in_ctrl <= i_din_ctrl;
                r_wr_en        <= (r_state == ST_SEND) ? w_sel_onehot : '1;
            end else begin
                r_wr_en <= '0;
            end
        end
    end

    assign o_unit_in       = r_unit_in;
    assign o_unit_in_ctrl  = r_unit_in_ctrl;
    assign o_unit_in_wr_en = r_wr_en;
    assign o_idle          = (r_state == ST_IDLE) && !(|w_hold_mask);
    assign o_err_protocol  = r_err;
    assign o_pkt_count     = r_pkt_count;

endmodule

// File: doc/sha512unit_dispatcher.md
Name: sha512unit_dispatcher

Overview:
Feeds internal packets from the upstream packet FIFO into N sha512unit instances over one shared input bus.
- Data packets go to one idle unit, chosen round-robin, with that unit's almost-full flag honoured word by word.
- Init packets are broadcast to all units, and only after every unit reports ready.
- Sits between pkt_comm's TX arbiter output FIFO and the array of sha512units.

Parameters:
N_UNITS, 4, number of sha512unit instances served (1..16)
UNIT_INPUT_WIDTH, 8, word width of upstream data and of the unit input bus
HOLDOFF, 4, cycles a unit is masked from reselection after its packet terminator is written

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
din  in  UNIT_INPUT_WIDTH  upstream word (FWFT FIFO head)
din_ctrl  in  1  upstream word is a control word (header or terminator)
din_empty  in  1  upstream FIFO empty
din_rd_en  out  1  pop upstream word (combinational)
unit_in  out  UNIT_INPUT_WIDTH  registered shared input bus to all units
unit_in_ctrl  out  1  registered control flag to all units
unit_in_wr_en  out  N_UNITS  registered per-unit write enable
unit_in_afull  in  N_UNITS  per-unit almost-full; has at least 2 words slack
unit_in_ready  in  N_UNITS  per-unit idle/ready for a new packet
idle  out  1  in IDLE state and no holdoff active
err_protocol  out  1  sticky: a data word arrived where a header was expected
pkt_count  out  16  count of data packets dispatched, wraps at 2^16

Behaviour:
- Reset (async, RESET_N low) values:
  - unit_in=0, unit_in_ctrl=0, unit_in_wr_en=0, err_protocol=0, pkt_count=0.
  - rr_ptr=0, all holdoff counters 0, state=IDLE.
  - din_rd_en=0 while in reset.
- Reset mid-packet: the packet is abandoned; no completion word is emitted.
- Packet format:
  - Data packet: header (ctrl=1, din[2:0]!=3'b001), then data words (ctrl=0), then a terminator (ctrl=1).
  - Init packet: header (ctrl=1, din[2:0]==3'b001), then terminator (ctrl=1).
- Transfer rule: din_rd_en = ~din_empty & state in {SEND, INIT_SEND} & ~gate.
  - gate = unit_in_afull[sel] in SEND; gate = |unit_in_afull in INIT_SEND.
  - A popped word appears on unit_in/unit_in_ctrl, with the wr_en bit(s) set, on the next cycle (latency 1).
  - wr_en is 0 in every cycle with no pop.
- IDLE:
  - Head is a non-ctrl word: pop and discard it, set err_protocol, stay in IDLE.
  - Head is a data header: go to SELECT (no pop).
  - Head is an init header: go to INIT_WAIT (no pop).
- SELECT:
  - avail = unit_in_ready & ~holdoff_mask.
  - If avail != 0, sel = first set bit at or after rr_ptr with wrap-around; go to SEND.
  - Otherwise wait in SELECT.
  - Selection is done in the same cycle avail is seen.
- SEND:
  - Forward words to sel; the first popped word is the header.
  - Popping a ctrl word other than the first ends the packet:
    - go to IDLE;
    - rr_ptr = sel+1 (mod N_UNITS);
    - pkt_count++;
    - holdoff[sel]=HOLDOFF.
  - unit_in_ready is not re-examined during SEND.
- INIT_WAIT: when &unit_in_ready and no holdoff is active, go to INIT_SEND.
- INIT_SEND:
  - Forward words with all wr_en bits set.
  - Popping the second ctrl word returns to IDLE.
  - pkt_count is unchanged.
- Holdoff: each counter decrements to 0 once per cycle. A unit with a nonzero counter is excluded from SELECT and INIT_WAIT.
- Simultaneous events:
  - Terminator pop and holdoff load in the same cycle: the load wins.
  - afull rising in the same cycle as a pop: that pop is allowed because gate is sampled that cycle; afull slack covers the in-flight word.
- din_empty mid-packet: stall in the current state with outputs wr_en=0.

Decomposition:
- Shared package sha512.vh holds:
  - UNIT_INPUT_WIDTH;
  - header type codes (PKT_TYPE_DATA=3'b000, PKT_TYPE_INIT=3'b001);
  - state encodings.
- One sub-module: rr_select (N_UNITS-wide round-robin first-set-bit finder: inputs avail and rr_ptr; outputs sel and found). Pure combinational.

Test Plan:
1. Reset; N_UNITS=4, all ready; send one data packet (header 0x00, 44 data words, terminator) -> header word with unit_in_ctrl=1 and unit_in_wr_en=4'b0001 one cycle after pop; 44 words to unit 0; terminator with ctrl=1; pkt_count=1; rr_ptr=1.
2. Four back-to-back packets with all units ready, ready of each served unit dropping 2 cycles after its terminator -> wr_en sequence 0001, 0010, 0100, 1000; no unit reselected within HOLDOFF=4 cycles.
3. Hold unit_in_afull[sel]=1 for 10 cycles mid-packet -> din_rd_en=0 and wr_en=0 for exactly those cycles; no data lost or duplicated, checked by comparing unit-side and FIFO-side byte streams.
4. Init packet (header 0x09, terminator) while unit 2 is busy (ready=0) -> dispatcher waits in INIT_WAIT; once unit 2 is ready, header and terminator are written with wr_en=4'b1111; pkt_count unchanged.
5. Stray word 0x5A with ctrl=0 at IDLE -> popped and discarded; err_protocol=1 and stays 1; the following valid packet is dispatched normally.
6. Assert RESET_N low mid-SEND -> all outputs return to reset values immediately; after release, the next header is dispatched to unit 0.
